// File: rtl/st7735_pkg.sv
// Shared colour constants, pattern and FSM encodings for the ST7735 pixel source.
package st7735_pkg;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/st7735_pattern_rom.sv
// Combinational map from (pattern, x, line bits) to an RGB565 word; the parent registers it.
module st7735_pattern_rom
  import st7735_pkg::*;
#(
  parameter int          H_PIXELS    = 128,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  pattern_t    pattern,
  input  logic [7:0]  x,
  input  logic [4:0]  y_hi,
  output logic [15:0] color
);

  logic [10:0] x_scaled;
  logic [2:0]  bar_idx;

  always_comb begin
    x_scaled = {x, 3'b000};
    bar_idx  = 3'(x_scaled / 11'(H_PIXELS));
    color    = RGB_BLACK;
    case (pattern)
      PAT_BARS:  color = bar_color(bar_idx);
      // y_hi carries line bits [7:3], so y_hi[0] is line bit 3
      PAT_GRAD:  color = {y_hi, x[6:1], 5'h10};
      PAT_CHECK: color = (x[3] ^ y_hi[0]) ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID: color = SOLID_COLOR;
      default:   color = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/st7735_pattern_gen.sv
// Raster-order test-pattern source feeding the ST7735 serial driver via WRITE_EN/IS_BUSY.
module st7735_pattern_gen
  import st7735_pkg::*;
#(
  parameter int          H_PIXELS    = 128,
  parameter int          V_PIXELS    = 160,
  parameter logic [15:0] SOLID_COLOR = 16'hF800,
  parameter int          FRAME_HOLD  = 60,
  parameter int          ACK_TIMEOUT = 1023
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESET_N,
  input  logic        LCD_READY,
  input  logic        IS_BUSY,
  input  logic [1:0]  MODE,
  input  logic        AUTO,
  output logic [15:0] PIXEL_DATA,
  output logic        WRITE_EN,
  output logic [7:0]  PIXEL_X,
  output logic [7:0]  PIXEL_Y,
  output logic        FRAME_DONE,
  output logic [1:0]  ACTIVE_PATTERN,
  output logic        TIMEOUT_ERR
);

  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_PIXELS - 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam int FW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [FW-1:0] HOLD_LAST = FW'(FRAME_HOLD - 1);

  state_t        state, state_nxt;
  logic [7:0]    x_q, y_q, x_adv, y_adv, rom_x, rom_y;
  logic [15:0]   pixel_q, rom_color;
  pattern_t      active_q, auto_q, auto_adv, pat_new, rom_pat;
  logic [TW-1:0] ack_cnt;
  logic [FW-1:0] frame_cnt;
  logic          write_en, load_first, advance, frame_end, ack_expired;
  logic          frame_done_q, timeout_q, hold_wrap, last_pixel;

  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // LCD_READY low overrides every state so a dropped panel aborts the frame immediately
  always_comb begin
    state_nxt   = state;
    write_en    = (state == ST_ISSUE);
    load_first  = 1'b0;
    advance     = 1'b0;
    frame_end   = 1'b0;
    ack_expired = 1'b0;
    last_pixel  = (x_q == X_LAST) && (y_q == Y_LAST);
    if (!LCD_READY) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!IS_BUSY) begin
          state_nxt  = ST_ISSUE;
          load_first = 1'b1;
        end
        ST_ISSUE: state_nxt = IS_BUSY ? ST_WAIT_DONE : ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (IS_BUSY) begin
            state_nxt = ST_WAIT_DONE;
          end else if (ack_cnt >= ACK_LAST) begin
            state_nxt   = ST_ISSUE;
            ack_expired = 1'b1;
          end
        end
        ST_WAIT_DONE: if (!IS_BUSY) begin
          state_nxt = ST_ISSUE;
          advance   = 1'b1;
          frame_end = last_pixel;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hold_wrap = (frame_cnt == HOLD_LAST);
    auto_adv  = hold_wrap ? pattern_t'(auto_q + 2'd1) : auto_q;
    if (AUTO) pat_new = load_first ? auto_q : auto_adv;
    else      pat_new = pattern_t'(MODE);
    x_adv   = (x_q == X_LAST) ? 8'd0 : x_q + 8'd1;
    y_adv   = (x_q == X_LAST) ? ((y_q == Y_LAST) ? 8'd0 : y_q + 8'd1) : y_q;
    rom_pat = (load_first || frame_end) ? pat_new : active_q;
    rom_x   = load_first ? 8'd0 : x_adv;
    rom_y   = load_first ? 8'd0 : y_adv;
  end

  st7735_pattern_rom #(
    .H_PIXELS    (H_PIXELS),
    .SOLID_COLOR (SOLID_COLOR)
  ) u_rom (
    .pattern (rom_pat),
    .x       (rom_x),
    .y_hi    (rom_y[7:3]),
    .color   (rom_color)
  );

  // ack_cnt holds the number of cycles elapsed since the WRITE_EN cycle
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) begin
      x_q          <= '0;
      y_q          <= '0;
      pixel_q      <= '0;
      frame_done_q <= 1'b0;
      active_q     <= PAT_BARS;
      auto_q       <= PAT_BARS;
      timeout_q    <= 1'b0;
      frame_cnt    <= '0;
      ack_cnt      <= '0;
    end else begin
      frame_done_q <= frame_end;
      if (ack_expired) timeout_q <= 1'b1;
      if (state == ST_ISSUE)         ack_cnt <= TW'(1);
      else if (state == ST_WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
      else                           ack_cnt <= '0;
      if (frame_end) begin
        frame_cnt <= hold_wrap ? '0 : frame_cnt + 1'b1;
        auto_q    <= auto_adv;
      end
      if (!LCD_READY) begin
        x_q <= '0;
        y_q <= '0;
      end else if (load_first || advance) begin
        x_q     <= rom_x;
        y_q     <= rom_y;
        pixel_q <= rom_color;
        if (load_first || frame_end) active_q <= pat_new;
      end
    end
  end

  assign WRITE_EN       = write_en;
  assign PIXEL_DATA     = pixel_q;
  assign PIXEL_X        = x_q;
  assign PIXEL_Y        = y_q;
  assign FRAME_DONE     = frame_done_q;
  assign ACTIVE_PATTERN = active_q;
  assign TIMEOUT_ERR    = timeout_q;

endmodule

// File: tb/tb_st7735_pattern_gen.sv
// Directed bench: instance 0 is the full 128x160 panel, 1 is 8x4 with AUTO hold 2, 2 is 16x2.
module tb_st7735_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ready [3];
  logic        busy  [3];
  logic        auto_i[3];
  logic [1:0]  mode  [3];
  logic [15:0] pdata [3];
  logic        we    [3];
  logic        fd    [3];
  logic        terr  [3];
  logic [7:0]  px    [3];
  logic [7:0]  py    [3];
  logic [1:0]  apat  [3];

  int checks = 0;
  int errors = 0;
  int fd_count[3];
  int we_count[3];

  st7735_pattern_gen #(.H_PIXELS(128), .V_PIXELS(160), .SOLID_COLOR(16'hF800),
                       .FRAME_HOLD(60), .ACK_TIMEOUT(20)) dut_a (
    .SYSTEM_CLK(clk), .RESET_N(reset_n), .LCD_READY(ready[0]), .IS_BUSY(busy[0]),
    .MODE(mode[0]), .AUTO(auto_i[0]), .PIXEL_DATA(pdata[0]), .WRITE_EN(we[0]),
    .PIXEL_X(px[0]), .PIXEL_Y(py[0]), .FRAME_DONE(fd[0]), .ACTIVE_PATTERN(apat[0]),
    .TIMEOUT_ERR(terr[0]));

  st7735_pattern_gen #(.H_PIXELS(8), .V_PIXELS(4), .SOLID_COLOR(16'hF800),
                       .FRAME_HOLD(2), .ACK_TIMEOUT(20)) dut_b (
    .SYSTEM_CLK(clk), .RESET_N(reset_n), .LCD_READY(ready[1]), .IS_BUSY(busy[1]),
    .MODE(mode[1]), .AUTO(auto_i[1]), .PIXEL_DATA(pdata[1]), .WRITE_EN(we[1]),
    .PIXEL_X(px[1]), .PIXEL_Y(py[1]), .FRAME_DONE(fd[1]), .ACTIVE_PATTERN(apat[1]),
    .TIMEOUT_ERR(terr[1]));

  st7735_pattern_gen #(.H_PIXELS(16), .V_PIXELS(2), .SOLID_COLOR(16'hF800),
                       .FRAME_HOLD(60), .ACK_TIMEOUT(20)) dut_c (
    .SYSTEM_CLK(clk), .RESET_N(reset_n), .LCD_READY(ready[2]), .IS_BUSY(busy[2]),
    .MODE(mode[2]), .AUTO(auto_i[2]), .PIXEL_DATA(pdata[2]), .WRITE_EN(we[2]),
    .PIXEL_X(px[2]), .PIXEL_Y(py[2]), .FRAME_DONE(fd[2]), .ACTIVE_PATTERN(apat[2]),
    .TIMEOUT_ERR(terr[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fd[i]) fd_count[i]++;
      if (we[i]) we_count[i]++;
    end
  end

  function automatic logic [15:0] expBar(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic rdy, input logic [1:0] md,
                               input logic au);
    ready[sel]  = rdy;
    mode[sel]   = md;
    auto_i[sel] = au;
  endtask

  task automatic waitWe(input int sel, input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (we[sel]) seen = 1'b1;
    end
  endtask

  // Acts as the driver: captures the issued pixel, then holds IS_BUSY for busy_len cycles
  task automatic servePixel(input int sel, input int busy_len, input int limit,
                            output logic [7:0] x, output logic [7:0] y,
                            output logic [15:0] data, output logic [1:0] pat,
                            output logic done);
    logic seen;
    waitWe(sel, limit, seen);
    checkOutput($sformatf("write_en_seen_dut%0d", sel), 32'(seen), 32'd1);
    x    = px[sel];
    y    = py[sel];
    data = pdata[sel];
    pat  = apat[sel];
    done = fd[sel];
    if (seen) begin
      @(negedge clk);
      busy[sel] = 1'b1;
      repeat (busy_len) @(negedge clk);
      busy[sel] = 1'b0;
    end
  endtask

  initial begin
    logic [7:0]  x, y;
    logic [15:0] data;
    logic [1:0]  pat;
    logic        done, seen;
    int          snap, n;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i, 1'b0, 2'd0, 1'b0);
      busy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_write_en", 32'(we[0]), 32'd0);
    checkOutput("rst_pixel_data", 32'(pdata[0]), 32'd0);
    checkOutput("rst_x", 32'(px[0]), 32'd0);
    checkOutput("rst_y", 32'(py[0]), 32'd0);
    checkOutput("rst_frame_done", 32'(fd[0]), 32'd0);
    checkOutput("rst_pattern", 32'(apat[0]), 32'd0);
    checkOutput("rst_timeout", 32'(terr[0]), 32'd0);
    checkOutput("rst_write_en_b", 32'(we[1]), 32'd0);

    reset_n = 1'b1;
    snap = we_count[0];
    repeat (20) @(negedge clk);
    checkOutput("not_ready_no_write", 32'(we_count[0] - snap), 32'd0);

    $display("[TB] colour bars line on 128x160");
    applyStimulus(0, 1'b1, 2'd0, 1'b0);
    servePixel(0, 16, 2, x, y, data, pat, done);
    checkOutput("first_data", 32'(data), 32'hFFFF);
    checkOutput("first_x", 32'(x), 32'd0);
    checkOutput("first_y", 32'(y), 32'd0);
    checkOutput("first_pattern", 32'(pat), 32'd0);
    for (int i = 1; i < 128; i++) begin
      servePixel(0, 16, 40, x, y, data, pat, done);
      checkOutput($sformatf("bars_x%0d", i), 32'(x), 32'(i));
      checkOutput($sformatf("bars_y_x%0d", i), 32'(y), 32'd0);
      checkOutput($sformatf("bars_data_x%0d", i), 32'(data), 32'(expBar(i / 16)));
    end
    servePixel(0, 16, 40, x, y, data, pat, done);
    checkOutput("wrap_x", 32'(x), 32'd0);
    checkOutput("wrap_y", 32'(y), 32'd1);
    checkOutput("wrap_data", 32'(data), 32'hFFFF);

    $display("[TB] acknowledge timeout");
    waitWe(0, 40, seen);
    checkOutput("timeout_we_seen", 32'(seen), 32'd1);
    checkOutput("timeout_before", 32'(terr[0]), 32'd0);
    n = 0;
    while (n < 100 && !terr[0]) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_latency", 32'(n), 32'd20);
    checkOutput("timeout_reissue_we", 32'(we[0]), 32'd1);
    checkOutput("timeout_reissue_data", 32'(pdata[0]), 32'hFFFF);
    checkOutput("timeout_reissue_x", 32'(px[0]), 32'd1);
    checkOutput("timeout_reissue_y", 32'(py[0]), 32'd1);
    repeat (30) @(negedge clk);
    checkOutput("timeout_sticky", 32'(terr[0]), 32'd1);
    applyStimulus(0, 1'b0, 2'd0, 1'b0);

    $display("[TB] frame wrap with AUTO on 8x4");
    applyStimulus(1, 1'b1, 2'd0, 1'b1);
    for (int f = 0; f < 9; f++) begin
      for (int p = 0; p < 32; p++) begin
        servePixel(1, 2, 40, x, y, data, pat, done);
        checkOutput($sformatf("auto_x_f%0d_p%0d", f, p), 32'(x), 32'(p % 8));
        checkOutput($sformatf("auto_y_f%0d_p%0d", f, p), 32'(y), 32'(p / 8));
        if (p == 0) begin
          checkOutput($sformatf("auto_pattern_f%0d", f), 32'(pat), 32'((f / 2) % 4));
          checkOutput($sformatf("auto_frame_done_f%0d", f), 32'(done), 32'(f != 0));
        end
        if (p == 1) checkOutput($sformatf("auto_pulse_end_f%0d", f), 32'(done), 32'd0);
        if (f == 0 && p == 5)  checkOutput("bars8_x5", 32'(data), 32'hF800);
        if (f == 2 && p == 0)  checkOutput("grad_0_0", 32'(data), 32'h0010);
        if (f == 2 && p == 21) checkOutput("grad_5_2", 32'(data), 32'h0050);
        if (f == 4 && p == 9)  checkOutput("check_1_1", 32'(data), 32'h0000);
        if (f == 6 && p == 13) checkOutput("solid_5_1", 32'(data), 32'hF800);
      end
    end

    $display("[TB] abort in WAIT_DONE at (5,2)");
    for (int p = 0; p < 21; p++) begin
      servePixel(1, 2, 40, x, y, data, pat, done);
      if (p == 0) checkOutput("abort_frame_pattern", 32'(pat), 32'd0);
    end
    waitWe(1, 40, seen);
    checkOutput("abort_we_seen", 32'(seen), 32'd1);
    checkOutput("abort_at_x", 32'(px[1]), 32'd5);
    checkOutput("abort_at_y", 32'(py[1]), 32'd2);
    @(negedge clk);
    busy[1] = 1'b1;
    repeat (3) @(negedge clk);
    snap = fd_count[1];
    applyStimulus(1, 1'b0, 2'd0, 1'b1);
    busy[1] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_x_cleared", 32'(px[1]), 32'd0);
    checkOutput("abort_y_cleared", 32'(py[1]), 32'd0);
    checkOutput("abort_no_write", 32'(we[1]), 32'd0);
    applyStimulus(1, 1'b1, 2'd0, 1'b1);
    servePixel(1, 2, 5, x, y, data, pat, done);
    checkOutput("restart_x", 32'(x), 32'd0);
    checkOutput("restart_y", 32'(y), 32'd0);
    checkOutput("restart_data", 32'(data), 32'hFFFF);
    checkOutput("restart_pattern", 32'(pat), 32'd0);
    checkOutput("restart_no_done", 32'(done), 32'd0);
    checkOutput("abort_done_count", 32'(fd_count[1] - snap), 32'd0);
    for (int p = 1; p < 32; p++) servePixel(1, 2, 40, x, y, data, pat, done);
    servePixel(1, 2, 40, x, y, data, pat, done);
    checkOutput("after_abort_pattern", 32'(pat), 32'd1);
    checkOutput("after_abort_done", 32'(done), 32'd1);
    applyStimulus(1, 1'b0, 2'd0, 1'b1);

    $display("[TB] mid-frame MODE change on 16x2");
    applyStimulus(2, 1'b1, 2'd0, 1'b0);
    for (int p = 0; p < 32; p++) begin
      servePixel(2, 2, 40, x, y, data, pat, done);
      if (p == 0) checkOutput("mode_frame0_pattern", 32'(pat), 32'd0);
      checkOutput($sformatf("mode_x_p%0d", p), 32'(x), 32'(p % 16));
      checkOutput($sformatf("mode_data_p%0d", p), 32'(data), 32'(expBar((p % 16) / 2)));
      if (p == 9) applyStimulus(2, 1'b1, 2'd2, 1'b0);
    end
    servePixel(2, 2, 40, x, y, data, pat, done);
    checkOutput("mode_next_pattern", 32'(pat), 32'd2);
    checkOutput("mode_next_0_0", 32'(data), 32'h0000);
    checkOutput("mode_next_done", 32'(done), 32'd1);
    for (int p = 1; p < 9; p++) begin
      servePixel(2, 2, 40, x, y, data, pat, done);
      if (p == 8) begin
        checkOutput("mode_next_x8", 32'(x), 32'd8);
        checkOutput("mode_next_8_0", 32'(data), 32'hFFFF);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
